// File: rtl/exchange_seq.sv
// exchange_seq: sequences the per-round exp/opt/shift strobes shared by all replicas
module exchange_seq #(
    parameter int EXP_CYCLES = 17,
    parameter int NODE_NUM   = 32,
    parameter int BASE_NUM   = 2,
    localparam int BW        = (BASE_NUM > 1) ? $clog2(BASE_NUM) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   rounds,
    input  logic          thr_mode,
    output logic          busy,
    output logic          done,
    output logic          round_done,
    output logic          exp_init,
    output logic          exp_run,
    output logic          exp_fin,
    output logic          opt_run,
    output logic          opt_com_thr,
    output logic [BW-1:0] base_id,
    output logic          exchange_shift_d,
    output logic [15:0]   round_cnt
);
    localparam int CMAX = (EXP_CYCLES > NODE_NUM) ? EXP_CYCLES : NODE_NUM;
    localparam int CW   = $clog2(CMAX);

    typedef enum logic [2:0] {IDLE, INIT, RUN, FIN, OPT, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   rounds_q, rounds_d;
    logic [15:0]   round_cnt_q, round_cnt_d;
    logic [BW-1:0] base_id_q, base_id_d;
    logic          thr_q, thr_d;
    logic          last;

    assign last = ({1'b0, round_cnt_q} + 17'd1) == {1'b0, rounds_q};

    // next-state: phase walk, phase counter and per-round bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rounds_d    = rounds_q;
        round_cnt_d = round_cnt_q;
        base_id_d   = base_id_q;
        thr_d       = thr_q;
        case (state_q)
            IDLE: if (start) begin
                rounds_d    = (rounds == 16'd0) ? 16'd1 : rounds;
                thr_d       = thr_mode;
                round_cnt_d = 16'd0;
                state_d     = thr_mode ? OPT : INIT;
            end
            INIT: begin
                cnt_d   = CW'(EXP_CYCLES - 1);
                state_d = RUN;
            end
            RUN: begin
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? FIN : RUN;
            end
            FIN: state_d = OPT;
            OPT: begin
                cnt_d   = CW'(NODE_NUM - 2);
                state_d = thr_q ? DONE : SHIFT;
            end
            SHIFT: begin
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? DONE : SHIFT;
            end
            DONE: begin
                round_cnt_d = round_cnt_q + 16'd1;
                base_id_d   = (base_id_q == BW'(BASE_NUM - 1)) ? '0 : base_id_q + 1'b1;
                state_d     = last ? IDLE : (thr_q ? OPT : INIT);
            end
            default: state_d = IDLE;
        endcase
    end

    // state and bookkeeping registers; base_id survives runs, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rounds_q    <= 16'd0;
            round_cnt_q <= 16'd0;
            base_id_q   <= '0;
            thr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rounds_q    <= rounds_d;
            round_cnt_q <= round_cnt_d;
            base_id_q   <= base_id_d;
            thr_q       <= thr_d;
        end
    end

    assign busy             = state_q != IDLE;
    assign round_done       = state_q == DONE;
    assign done             = (state_q == DONE) && last;
    assign exp_init         = state_q == INIT;
    assign exp_run          = state_q == RUN;
    assign exp_fin          = state_q == FIN;
    assign opt_run          = state_q == OPT;
    assign exchange_shift_d = state_q == SHIFT;
    assign opt_com_thr      = thr_q;
    assign base_id          = base_id_q;
    assign round_cnt        = round_cnt_q;
endmodule

// File: tb/tb_exchange_seq.sv
// tb_exchange_seq: scoreboard bench for exchange_seq with E=4, N=4, BASE_NUM=2
module tb_exchange_seq;
    localparam int E = 4;
    localparam int N = 4;
    localparam int B = 2;

    typedef logic [25:0] vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] rounds = 16'd0;
    logic        thr_mode = 1'b0;
    logic        busy, done, round_done, exp_init, exp_run, exp_fin, opt_run;
    logic        opt_com_thr, exchange_shift_d;
    logic [0:0]  base_id;
    logic [15:0] round_cnt;

    int    tests = 0;
    int    fails = 0;
    int    m_base = 0;
    int    m_rc = 0;
    string tag = "reset";
    vec_t  q[$];
    vec_t  exp_v;

    int   sc = 0;
    logic sh_prev = 1'b0;
    logic fin_prev = 1'b0;
    logic xopt_prev = 1'b0;

    exchange_seq #(.EXP_CYCLES(E), .NODE_NUM(N), .BASE_NUM(B)) dut (
        .clk(clk), .reset(reset), .start(start), .rounds(rounds), .thr_mode(thr_mode),
        .busy(busy), .done(done), .round_done(round_done), .exp_init(exp_init),
        .exp_run(exp_run), .exp_fin(exp_fin), .opt_run(opt_run), .opt_com_thr(opt_com_thr),
        .base_id(base_id), .exchange_shift_d(exchange_shift_d), .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic b, input logic d, input logic rd, input logic [4:0] s,
                                input logic t, input logic bi, input logic [15:0] rc);
        return {b, d, rd, s, t, bi, rc};
    endfunction

    function automatic vec_t obs();
        return {busy, done, round_done, exp_init, exp_run, exp_fin, opt_run, exchange_shift_d,
                opt_com_thr, base_id, round_cnt};
    endfunction

    task automatic push_idle(input logic t);
        q.push_back(mk(1'b0, 1'b0, 1'b0, 5'b00000, t, 1'(m_base), 16'(m_rc)));
    endtask

    // expected cycle-by-cycle outputs of one run, starting with the cycle after start
    task automatic push_run(input int r, input logic t);
        int n;
        n = (r == 0) ? 1 : r;
        m_rc = 0;
        for (int k = 0; k < n; k++) begin
            if (!t) begin
                q.push_back(mk(1'b1, 1'b0, 1'b0, 5'b10000, t, 1'(m_base), 16'(m_rc)));
                repeat (E) q.push_back(mk(1'b1, 1'b0, 1'b0, 5'b01000, t, 1'(m_base), 16'(m_rc)));
                q.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00100, t, 1'(m_base), 16'(m_rc)));
            end
            q.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00010, t, 1'(m_base), 16'(m_rc)));
            if (!t) repeat (N - 1) q.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00001, t, 1'(m_base), 16'(m_rc)));
            q.push_back(mk(1'b1, k == n - 1, 1'b1, 5'b00000, t, 1'(m_base), 16'(m_rc)));
            m_rc++;
            m_base = (m_base + 1 == B) ? 0 : m_base + 1;
        end
        push_idle(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_v = q.pop_front();
            tests++;
            assert (obs() === exp_v) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", tag, obs(), exp_v);
            end
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 2000) begin
            step();
            guard++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $error("FAIL %s timeout observed=%0d pending expected=0", tag, q.size());
            q.delete();
        end
    endtask

    task automatic kick(input int r, input logic t);
        start = 1'b1;
        rounds = 16'(r);
        thr_mode = t;
        push_run(r, t);
        step();
        start = 1'b0;
    endtask

    // protocol monitor: strobe exclusivity, FIN->OPT, exchange OPT->N-1 SHIFT cycles
    always @(negedge clk) begin
        if (reset) begin
            sc = 0;
            sh_prev = 1'b0;
            fin_prev = 1'b0;
            xopt_prev = 1'b0;
        end else begin
            tests++;
            assert ($countones({exp_init, exp_run, exp_fin, opt_run, exchange_shift_d}) <= 1) else begin
                fails++;
                $error("FAIL onehot observed=%b expected=at most one",
                       {exp_init, exp_run, exp_fin, opt_run, exchange_shift_d});
            end
            if (fin_prev) begin
                tests++;
                assert (opt_run === 1'b1) else begin
                    fails++;
                    $error("FAIL fin_then_opt observed=%b expected=1", opt_run);
                end
            end
            if (xopt_prev) begin
                tests++;
                assert (exchange_shift_d === 1'b1) else begin
                    fails++;
                    $error("FAIL opt_then_shift observed=%b expected=1", exchange_shift_d);
                end
            end
            if (sh_prev && !exchange_shift_d) begin
                tests++;
                assert (sc == N - 1) else begin
                    fails++;
                    $error("FAIL shift_len observed=%0d expected=%0d", sc, N - 1);
                end
                sc = 0;
            end
            if (exchange_shift_d) sc++;
            fin_prev = exp_fin;
            xopt_prev = opt_run && !opt_com_thr;
            sh_prev = exchange_shift_d;
        end
    end

    initial begin
        tag = "reset";
        repeat (2) push_idle(1'b0);
        repeat (2) step();
        reset = 1'b0;
        push_idle(1'b0);
        step();
        tag = "single";
        kick(1, 1'b0);
        drain();
        tag = "b2b3";
        kick(3, 1'b0);
        drain();
        tag = "thr2";
        kick(2, 1'b1);
        thr_mode = 1'b0;
        drain();
        tag = "r0_restart";
        kick(0, 1'b0);
        step();
        step();
        start = 1'b1;
        rounds = 16'd5;
        step();
        start = 1'b0;
        drain();
        tag = "shift_reset";
        kick(1, 1'b0);
        repeat (7) step();
        reset = 1'b1;
        q.delete();
        m_base = 0;
        m_rc = 0;
        push_idle(1'b0);
        step();
        reset = 1'b0;
        repeat (3) push_idle(1'b0);
        repeat (3) step();
        tag = "after_reset";
        kick(2, 1'b0);
        drain();
        tag = "random";
        for (int i = 0; i < 8; i++) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin
                push_idle(opt_com_thr === 1'b1 ? 1'b0 : 1'b0);
                q[q.size() - 1][17] = thr_mode;
                step();
            end
            kick($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            rounds = 16'($urandom);
            thr_mode = 1'($urandom_range(0, 1));
            drain();
            thr_mode = q.size() == 0 ? opt_com_thr_model() : thr_mode;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    logic last_thr = 1'b0;
    always @(posedge clk) if (start && !busy && !reset) last_thr <= thr_mode;

    function automatic logic opt_com_thr_model();
        return last_thr;
    endfunction
endmodule
